// File: rtl/bec_mul_arbiter_if.sv
// Handshake bundle between the BEC multiplier arbiter, its requesters
// and the shared GF(2^163) multiplier.
interface bec_mul_arbiter_if #(
    parameter int NREQ = 4,
    parameter int SW   = 2
);
    logic            en_i;
    logic [NREQ-1:0] req_i;
    logic            mul_done_i;
    logic [NREQ-1:0] gnt_o;
    logic [SW-1:0]   sel_o;
    logic            mul_start_o;
    logic [NREQ-1:0] ack_o;
    logic            busy_o;
    logic            err_o;

    modport master (
        input  en_i, req_i, mul_done_i,
        output gnt_o, sel_o, mul_start_o, ack_o, busy_o, err_o
    );

    modport slave (
        output en_i, req_i, mul_done_i,
        input  gnt_o, sel_o, mul_start_o, ack_o, busy_o, err_o
    );
endinterface

// File: rtl/bec_mul_arbiter.sv
// Round-robin arbiter and sequencer for the shared GF(2^163) multiplier.
// Optional BUSY abort timer is built when BEC_ARB_TIMEOUT_EN is defined.
module bec_mul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2000,
    parameter int CW      = 12,
    parameter int SW      = 2
) (
    input logic               wb_clk_i,
    input logic               wb_rst_ni,
    bec_mul_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        BUSY  = 2'b11,
        DONE  = 2'b10
    } state_t;

    if ((2 ** CW) <= TIMEOUT) begin : g_cw_chk
        $error("CW too narrow to hold TIMEOUT");
    end

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   pick;
    logic [SW-1:0]   sel;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic [NREQ-1:0] shifted;
    logic            found;
    logic            start;
    logic            busy;
    logic            err;
    logic            tmo;
    int              idx;

    // First pending request after the last winner, wrapping round the ring
    always_comb begin
        pick    = '0;
        found   = 1'b0;
        idx     = 0;
        shifted = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx     = (int'(ptr) + i) % NREQ;
            shifted = bus.req_i >> idx;
            if (!found && shifted[0]) begin
                found = 1'b1;
                pick  = SW'(idx);
            end
        end
    end

`ifdef BEC_ARB_TIMEOUT_EN
    logic [CW-1:0] cnt;

    assign tmo = (cnt == CW'(TIMEOUT - 1));

    // BUSY cycle counter, zero on BUSY entry
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            cnt <= '0;
        end else if (state != BUSY) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Grant / start / wait / acknowledge sequencer with registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= IDLE;
            ptr   <= SW'(NREQ - 1);
            gnt   <= '0;
            sel   <= '0;
            start <= 1'b0;
            ack   <= '0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            start <= 1'b0;
            ack   <= '0;
            err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.en_i && found) begin
                        gnt   <= NREQ'(1) << pick;
                        sel   <= pick;
                        start <= 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= BUSY;
                end
                BUSY: begin
                    if (bus.mul_done_i || tmo) begin
                        ack   <= gnt;
                        err   <= tmo & ~bus.mul_done_i;
                        state <= DONE;
                    end
                end
                DONE: begin
                    ptr   <= sel;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt_o       = gnt;
    assign bus.sel_o       = sel;
    assign bus.mul_start_o = start;
    assign bus.ack_o       = ack;
    assign bus.busy_o      = busy;
    assign bus.err_o       = err;

endmodule

// File: tb/tb_bec_mul_arbiter.sv
// Directed bench for bec_mul_arbiter: vector table plus corner sequences.
// Timeout sequences run only when BEC_ARB_TIMEOUT_EN is defined.
module tb_bec_mul_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    bec_mul_arbiter_if #(.NREQ(4), .SW(2)) bif ();

    bec_mul_arbiter #(
        .NREQ(4),
        .TIMEOUT(16),
        .CW(12),
        .SW(2)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .bus      (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         lat;
        logic [1:0] sel;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One transaction from an IDLE cycle; req/en change at first BUSY cycle
    task automatic txn(input logic [3:0] rq, input logic [3:0] rq_mid,
                       input logic en_mid, input int lat,
                       input logic [1:0] exp_sel);
        logic [3:0] oh;
        oh = 4'b0001 << exp_sel;
        bif.req_i = rq;
        step();
        chk("issue_gnt", bif.gnt_o, oh);
        chk("issue_sel", bif.sel_o, exp_sel);
        chk("issue_start", bif.mul_start_o, 1);
        chk("issue_busy", bif.busy_o, 1);
        step();
        chk("start_pulse", bif.mul_start_o, 0);
        bif.req_i = rq_mid;
        bif.en_i  = en_mid;
        repeat (lat - 1) step();
        chk("ack_early", bif.ack_o, 0);
        bif.mul_done_i = 1'b1;
        step();
        bif.mul_done_i = 1'b0;
        chk("ack", bif.ack_o, oh);
        chk("ack_err", bif.err_o, 0);
        chk("done_gnt", bif.gnt_o, oh);
        step();
        chk("idle_busy", bif.busy_o, 0);
        chk("idle_gnt", bif.gnt_o, 0);
        chk("idle_ack", bif.ack_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        checks = 0;
        errors = 0;
        tbl[0]  = '{4'hF,    5, 2'd0};
        tbl[1]  = '{4'hF,    5, 2'd1};
        tbl[2]  = '{4'hF,    5, 2'd2};
        tbl[3]  = '{4'hF,    5, 2'd3};
        tbl[4]  = '{4'hF,    5, 2'd0};
        tbl[5]  = '{4'b0100, 5, 2'd2};
        tbl[6]  = '{4'b0011, 1, 2'd0};
        tbl[7]  = '{4'b0011, 2, 2'd1};
        tbl[8]  = '{4'b1001, 3, 2'd3};
        tbl[9]  = '{4'b1000, 1, 2'd3};
        tbl[10] = '{4'b0010, 4, 2'd1};

        rst_n          = 1'b0;
        bif.en_i       = 1'b1;
        bif.req_i      = 4'hF;
        bif.mul_done_i = 1'b0;
        repeat (3) step();
        chk("rst_gnt", bif.gnt_o, 0);
        chk("rst_sel", bif.sel_o, 0);
        chk("rst_start", bif.mul_start_o, 0);
        chk("rst_ack", bif.ack_o, 0);
        chk("rst_busy", bif.busy_o, 0);
        chk("rst_err", bif.err_o, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].req, tbl[i].req, 1'b1, tbl[i].lat, tbl[i].sel);
        end

        bif.en_i  = 1'b0;
        bif.req_i = 4'b0011;
        seen = 1'b0;
        repeat (20) begin
            step();
            if (bif.busy_o || bif.gnt_o != 0) seen = 1'b1;
        end
        chk("en_gate", seen, 0);

        bif.en_i = 1'b1;
        txn(4'b0011, 4'b0011, 1'b0, 3, 2'd0);
        seen = 1'b0;
        repeat (10) begin
            step();
            if (bif.busy_o || bif.gnt_o != 0) seen = 1'b1;
        end
        chk("en_drop", seen, 0);

        bif.en_i  = 1'b1;
        bif.req_i = 4'b0001;
        step();
        chk("rmid_sel", bif.sel_o, 0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rmid_gnt", bif.gnt_o, 0);
        chk("rmid_busy", bif.busy_o, 0);
        bif.req_i = 4'b0011;
        step();
        chk("rmid_ack", bif.ack_o, 0);
        rst_n = 1'b1;
        txn(4'b0011, 4'b0011, 1'b1, 2, 2'd0);

        txn(4'b0010, 4'b0100, 1'b1, 4, 2'd1);
        txn(4'b0100, 4'b0100, 1'b1, 2, 2'd2);
        txn(4'b0001, 4'b0001, 1'b1, 1, 2'd0);

`ifdef BEC_ARB_TIMEOUT_EN
        bif.req_i = 4'b1000;
        step();
        chk("to_sel", bif.sel_o, 3);
        step();
        repeat (15) step();
        chk("to_ack_early", bif.ack_o, 0);
        chk("to_busy", bif.busy_o, 1);
        step();
        chk("to_ack", bif.ack_o, 4'b1000);
        chk("to_err", bif.err_o, 1);
        step();
        chk("to_idle", bif.busy_o, 0);
        chk("to_err_clr", bif.err_o, 0);
        txn(4'b1000, 4'b1000, 1'b1, 16, 2'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
